wave_loader: RTL

Write-side companion to the dual-port sine ROM playback path. It accepts a stream of waveform samples over a valid/ready handshake and writes them into consecutive addresses of an external dual-port wave RAM, starting at a programmable base and wrapping modulo table size. It lets the signal generator replace its lookup table at runtime instead of relying on a fixed ROM image. Playback blocks read the same RAM through its other port.

---
 rtl/wave_loader_pkg.sv | 16 +
 rtl/wave_loader_counter.sv | 44 ++++
 rtl/wave_loader.sv | 121 ++++++++++++
 3 files changed

// File: rtl/wave_loader_pkg.sv
// Shared definitions for the wave RAM write path.
//   state_e      : loader FSM states (IDLE, LOAD, DONE)
//   DEF_A_WIDTH  : default wave RAM address width, shared with sinegen and the RAM
//   DEF_D_WIDTH  : default sample width
package wave_loader_pkg;

  localparam int unsigned DEF_A_WIDTH = 8;
  localparam int unsigned DEF_D_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/wave_loader_counter.sv
// Offset counter for wave_loader.
//   clk, rst   : clock, asynchronous active-low reset
//   clr        : zero the offset (takes priority over inc)
//   inc        : advance offset by one
//   len        : number of samples minus one for this load
//   addr_off   : low A_WIDTH bits of the offset, used for the RAM address
//   last       : current offset equals len, so the next beat is the final one
module load_counter #(
  parameter int unsigned A_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  input  logic [A_WIDTH-1:0] len,
  output logic [A_WIDTH-1:0] addr_off,
  output logic               last
);

  // One extra bit so a full-table load (len = 2^A_WIDTH-1) can step past len
  // without aliasing back to zero.
  logic [A_WIDTH:0] offset_q, offset_d;

  always_comb begin
    offset_d = offset_q;
    if (clr) begin
      offset_d = '0;
    end else if (inc) begin
      offset_d = offset_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      offset_q <= '0;
    end else begin
      offset_q <= offset_d;
    end
  end

  assign addr_off = offset_q[A_WIDTH-1:0];
  assign last     = (offset_q == {1'b0, len});

endmodule

// File: rtl/wave_loader.sv
// Streams waveform samples into consecutive addresses of a dual-port wave RAM.
//   clk, rst         : clock, asynchronous active-low reset
//   start, base, len : begin a load at base for len+1 samples (sampled in IDLE)
//   abort            : end a load early, no done pulse
//   in_valid/in_data : sample stream; in_ready is high only while loading
//   wr_en/addr/data  : registered RAM write port, one cycle after each beat
//   busy             : load in progress
//   done             : one-cycle pulse alongside the final write
module wave_loader
  import wave_loader_pkg::*;
#(
  parameter int unsigned A_WIDTH = DEF_A_WIDTH,
  parameter int unsigned D_WIDTH = DEF_D_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] base,
  input  logic [A_WIDTH-1:0] len,
  input  logic               abort,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic               wr_en,
  output logic [A_WIDTH-1:0] wr_addr,
  output logic [D_WIDTH-1:0] wr_data,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] base_q, base_d;
  logic [A_WIDTH-1:0] len_q, len_d;
  logic               wr_en_q, wr_en_d;
  logic [A_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [D_WIDTH-1:0] wr_data_q, wr_data_d;

  logic               beat;
  logic               cnt_clr;
  logic               last;
  logic [A_WIDTH-1:0] addr_off;

  load_counter #(
    .A_WIDTH(A_WIDTH)
  ) u_load_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (beat),
    .len      (len_q),
    .addr_off (addr_off),
    .last     (last)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    cnt_clr   = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    beat      = (state_q == ST_LOAD) && in_valid;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base;
          len_d   = len;
          cnt_clr = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + addr_off;  // carry discarded: wraps mod table size
          wr_data_d = in_data;
        end
        // A beat in the abort cycle is still written; abort only redirects the FSM.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (beat && last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign in_ready = (state_q == ST_LOAD);
  assign busy     = (state_q == ST_LOAD);
  assign done     = (state_q == ST_DONE);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule
